// File: rtl/apb_pkg.sv
// Shared types and limits for the APB register-file slave.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_slv_state_t;

    localparam int APB_MAX_WAIT = 15;
    localparam int WAIT_CNT_W   = $clog2(APB_MAX_WAIT + 1);

    // Error reason, used by benches when reporting a rejected access.
    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_ALIGN = 2'd2
    } apb_err_t;

endpackage

// File: rtl/apb_reg_bank.sv
// Register array: one write port with optional byte strobes, one combinational read port.
// Strobe input exists only when APB_PSTRB_EN is defined.
module apb_reg_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0] wstrb,
`endif
    output logic [DATA_W-1:0] rdata
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [DATA_W-1:0]               wmask;
    logic                            in_range;

    // Non-power-of-two NUM_REGS leaves unused index codes; they read as 0.
    assign in_range = int'(idx) < NUM_REGS;

`ifdef APB_PSTRB_EN
    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_W/8; b++)
            wmask[8*b +: 8] = {8{wstrb[b]}};
    end
`else
    assign wmask = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            regs <= '0;
        else if (we && in_range)
            regs[idx] <= (regs[idx] & ~wmask) | (wdata & wmask);
    end

    assign rdata = in_range ? regs[idx] : '0;

endmodule

// File: rtl/apb_regfile_slave.sv
// APB3 register-file slave: address decode, error check, wait-state FSM.
// Optional byte strobes (pstrb port) when APB_PSTRB_EN is defined.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0000_A000,
    parameter int                WAIT_CYCLES = 0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int AL    = $clog2(DATA_W/8);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_slv_state_t          state, state_nxt;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [IDX_W-1:0]        idx_q;
    logic                    wr_q, err_q;
    logic [ADDR_W-1:0]       offset, index;
    logic                    err, setup, we;
    logic [DATA_W-1:0]       rdata;

    // Unsigned subtraction: addresses below the base wrap to a huge offset.
    assign offset = paddr - BASE_ADDR;
    assign index  = offset >> AL;
    assign err    = (paddr < BASE_ADDR) || (index >= ADDR_W'(NUM_REGS))
                 || (offset[AL-1:0] != '0);
    assign setup  = psel && !penable;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (setup) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: begin
                if (!psel || !penable)        state_nxt = ST_IDLE;
                else if (wait_cnt == WAIT_CNT_W'(1)) state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (setup) begin
                    idx_q    <= index[IDX_W-1:0];
                    wr_q     <= pwrite;
                    err_q    <= err;
                    wait_cnt <= WAIT_CNT_W'(WAIT_CYCLES);
                end
                ST_WAIT: wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign we      = (state == ST_RESP) && wr_q && !err_q;
    assign pready  = (state == ST_RESP);
    assign pslverr = (state == ST_RESP) && err_q;
    assign prdata  = ((state == ST_RESP) && !wr_q && !err_q) ? rdata : '0;

    apb_reg_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk   (pclk),
        .rst   (preset),
        .we    (we),
        .idx   (idx_q),
        .wdata (pwdata),
`ifdef APB_PSTRB_EN
        .wstrb (pstrb),
`endif
        .rdata (rdata)
    );

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Self-checking bench: three slaves (0, 3 and 2 wait states) against a behavioural memory model.
module tb_apb_regfile_slave;

    localparam logic [31:0] BASE = 32'h0000_A000;
    localparam int          NREG = 8;

    logic        pclk = 1'b0;
    logic        rst_v [3];
    logic        psel_v [3];
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = 4'hF;
    logic [31:0] prdata_v [3];
    logic        pready_v [3];
    logic        pslverr_v [3];

    logic [31:0] mem [3][NREG];
    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_regfile_slave #(.WAIT_CYCLES(0)) u_w0 (
        .pclk(pclk), .preset(rst_v[0]), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]));

    apb_regfile_slave #(.WAIT_CYCLES(3)) u_w3 (
        .pclk(pclk), .preset(rst_v[1]), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]));

    apb_regfile_slave #(.WAIT_CYCLES(2)) u_w2 (
        .pclk(pclk), .preset(rst_v[2]), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2]));

    function automatic int waits_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 2;
    endfunction

    // Reference: an access is legal only if word-aligned and inside the NREG-word window.
    function automatic void model(input int k, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [3:0] strb,
                                  output logic [31:0] erd, output logic eerr);
        longint a = longint'(addr);
        int     i;
        eerr = (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * NREG) || (a % 4 != 0);
        erd  = '0;
        if (!eerr) begin
            i = int'((a - longint'(BASE)) / 4);
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mem[k][i][8*b +: 8] = data[8*b +: 8];
            end else begin
                erd = mem[k][i];
            end
        end
    endfunction

    // Starts at posedge+1, ends at posedge+1 after the response with the bus released.
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rd, output logic err,
                        output int lat);
        bit done = 0;
        psel_v[k] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge pclk);
        checks++;
        if (pready_v[k] !== 1'b0) begin
            errors++; $display("FAIL setup_pready inst%0d got %b want 0", k, pready_v[k]);
        end
        @(posedge pclk); #1 penable = 1'b1;
        lat = 0; rd = '0; err = 1'b0;
        while (!done) begin
            @(negedge pclk); lat++;
            if (pready_v[k] === 1'b1) begin
                rd = prdata_v[k]; err = pslverr_v[k]; done = 1;
            end else begin
                checks++;
                if (prdata_v[k] !== '0 || pslverr_v[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_outputs inst%0d prdata %h pslverr %b want 0/0", k, prdata_v[k], pslverr_v[k]);
                end
                if (lat > 20) begin
                    checks++; errors++; done = 1;
                    $display("FAIL pready_timeout inst%0d addr %h got no pready want within %0d", k, addr, waits_of(k) + 1);
                end
            end
        end
        @(posedge pclk); #1 psel_v[k] = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin rst_v[k] = 1'b1; psel_v[k] = 1'b0; end
        for (int k = 0; k < 3; k++) for (int i = 0; i < NREG; i++) mem[k][i] = '0;
        repeat (2) @(negedge pclk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pready_v[k] !== 1'b0 || pslverr_v[k] !== 1'b0 || prdata_v[k] !== '0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d got pready %b pslverr %b prdata %h want 0/0/0",
                         k, pready_v[k], pslverr_v[k], prdata_v[k]);
            end
        end
        for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_basic;
        logic [31:0] rd, erd; logic err, eerr; int lat;
        model(0, 1, BASE + 32'hC, 32'hDEAD_BEEF, 4'hF, erd, eerr);
        xfer(0, 1, BASE + 32'hC, 32'hDEAD_BEEF, 4'hF, rd, err, lat);
        checks++;
        if (err !== 1'b0 || lat != 1) begin
            errors++; $display("FAIL basic_write err %b lat %0d want 0 1", err, lat);
        end
        model(0, 0, BASE + 32'hC, '0, 4'hF, erd, eerr);
        xfer(0, 0, BASE + 32'hC, '0, 4'hF, rd, err, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF || erd !== 32'hDEAD_BEEF || err !== 1'b0 || lat != 1) begin
            errors++; $display("FAIL basic_read got %h err %b lat %0d want deadbeef 0 1", rd, err, lat);
        end
    endtask

    task automatic test_wait_states;
        logic [31:0] rd; logic err; int lat;
        xfer(1, 0, BASE, '0, 4'hF, rd, err, lat);
        checks++;
        if (lat != 4 || rd !== '0 || err !== 1'b0) begin
            errors++; $display("FAIL wait3_read lat %0d prdata %h err %b want 4 0 0", lat, rd, err);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd, erd; logic err, eerr; int lat;
        logic [31:0] bad [2];
        bad[0] = BASE + 32'h20; bad[1] = BASE - 32'h4;
        for (int j = 0; j < 2; j++) begin
            model(0, 1, bad[j], 32'h5A5A_5A5A, 4'hF, erd, eerr);
            xfer(0, 1, bad[j], 32'h5A5A_5A5A, 4'hF, rd, err, lat);
            checks++;
            if (err !== 1'b1 || eerr !== 1'b1 || lat != 1) begin
                errors++; $display("FAIL range_write addr %h err %b lat %0d want 1 1", bad[j], err, lat);
            end
        end
        for (int i = 0; i < NREG; i++) begin
            model(0, 0, BASE + 32'(4 * i), '0, 4'hF, erd, eerr);
            xfer(0, 0, BASE + 32'(4 * i), '0, 4'hF, rd, err, lat);
            checks++;
            if (rd !== erd || err !== 1'b0) begin
                errors++; $display("FAIL regs_unchanged reg%0d got %h err %b want %h 0", i, rd, err, erd);
            end
        end
    endtask

    task automatic test_unaligned;
        logic [31:0] rd; logic err; int lat;
        xfer(0, 1, BASE + 32'h2, 32'h1234_5678, 4'hF, rd, err, lat);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL unaligned_write err %b want 1", err);
        end
        xfer(0, 0, BASE + 32'h2, '0, 4'hF, rd, err, lat);
        checks++;
        if (err !== 1'b1 || rd !== '0) begin
            errors++; $display("FAIL unaligned_read prdata %h err %b want 0 1", rd, err);
        end
    endtask

    task automatic test_pstrb;
`ifdef APB_PSTRB_EN
        logic [31:0] rd, erd; logic err, eerr; int lat;
        model(0, 1, BASE + 32'h4, 32'h1122_3344, 4'hF, erd, eerr);
        xfer(0, 1, BASE + 32'h4, 32'h1122_3344, 4'hF, rd, err, lat);
        model(0, 1, BASE + 32'h4, 32'hAABB_CCDD, 4'b0101, erd, eerr);
        xfer(0, 1, BASE + 32'h4, 32'hAABB_CCDD, 4'b0101, rd, err, lat);
        model(0, 1, BASE + 32'h4, 32'hFFFF_FFFF, 4'b0000, erd, eerr);
        xfer(0, 1, BASE + 32'h4, 32'hFFFF_FFFF, 4'b0000, rd, err, lat);
        checks++;
        if (err !== 1'b0 || lat != 1) begin
            errors++; $display("FAIL pstrb_zero_write err %b lat %0d want 0 1", err, lat);
        end
        model(0, 0, BASE + 32'h4, '0, 4'hF, erd, eerr);
        xfer(0, 0, BASE + 32'h4, '0, 4'hF, rd, err, lat);
        checks++;
        if (rd !== 32'h11BB_33DD || erd !== 32'h11BB_33DD) begin
            errors++; $display("FAIL pstrb_merge got %h want 11bb33dd", rd);
        end
`endif
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic err; int lat;
        psel_v[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h4;
        pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        @(posedge pclk); #1 penable = 1'b1;
        #2 rst_v[2] = 1'b1;
        #1;
        checks++;
        if (pready_v[2] !== 1'b0 || pslverr_v[2] !== 1'b0) begin
            errors++; $display("FAIL midreset_async pready %b pslverr %b want 0 0", pready_v[2], pslverr_v[2]);
        end
        @(negedge pclk);
        checks++;
        if (pready_v[2] !== 1'b0) begin
            errors++; $display("FAIL midreset_pready got %b want 0", pready_v[2]);
        end
        @(posedge pclk); #1;
        rst_v[2] = 1'b0; psel_v[2] = 1'b0; penable = 1'b0;
        for (int i = 0; i < NREG; i++) mem[2][i] = '0;
        xfer(2, 0, BASE + 32'h4, '0, 4'hF, rd, err, lat);
        checks++;
        if (rd !== '0 || err !== 1'b0 || lat != 3) begin
            errors++; $display("FAIL midreset_lost prdata %h err %b lat %0d want 0 0 3", rd, err, lat);
        end
        xfer(2, 1, BASE + 32'h4, 32'h0BAD_CAFE, 4'hF, rd, err, lat);
        mem[2][1] = 32'h0BAD_CAFE;
        xfer(2, 0, BASE + 32'h4, '0, 4'hF, rd, err, lat);
        checks++;
        if (rd !== mem[2][1] || err !== 1'b0 || lat != 3) begin
            errors++; $display("FAIL postreset_xfer prdata %h err %b lat %0d want 0badcafe 0 3", rd, err, lat);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, addr, data; logic err, eerr; logic [3:0] strb; int lat; bit wr;
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 40; n++) begin
                addr = BASE - 32'd8 + 32'($urandom_range(0, 48));
                wr   = 1'($urandom_range(0, 1));
                data = $urandom;
`ifdef APB_PSTRB_EN
                strb = 4'($urandom_range(0, 15));
`else
                strb = 4'hF;
`endif
                model(k, wr, addr, data, strb, erd, eerr);
                xfer(k, wr, addr, data, strb, rd, err, lat);
                checks++;
                if (rd !== erd || err !== eerr || lat != waits_of(k) + 1) begin
                    errors++;
                    $display("FAIL random inst%0d wr %0d addr %h got %h/%b/%0d want %h/%b/%0d",
                             k, wr, addr, rd, err, lat, erd, eerr, waits_of(k) + 1);
                end
                if ($urandom_range(0, 3) == 0) begin @(posedge pclk); #1; end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin rst_v[k] = 1'b1; psel_v[k] = 1'b0; end
        test_reset;
        test_basic;
        test_wait_states;
        test_errors;
        test_unaligned;
        test_pstrb;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
